hilihase_evt_bridge: RTL

- Synthesizable, parametrised successor to the co-simulation signal bridge.
- Samples NUM_CH single-bit probe signals every clock and detects changes.
- Queues timestamped change events in a FIFO for the host framework to drain over a valid/ready stream.
- Applies host drive commands (channel id + value) onto a bank of drive outputs.

---
 rtl/hilihase_evt_bridge.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hilihase_evt_bridge.sv
`default_nettype none
// ============================================================================
// Module  : hilihase_evt_bridge
// Brief   : Captures probe changes into a timestamped event FIFO and applies
//           host drive commands onto a bank of drive outputs.
// Rev     : 1.0  initial release
// ============================================================================
module hilihase_evt_bridge #(
    parameter int                NUM_CH   = 8,
    parameter int                TS_W     = 16,
    parameter int                DEPTH    = 16,
    parameter int                ID_W     = 4,
    parameter logic [NUM_CH-1:0] DRV_INIT = '0,
    parameter int                CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_CH-1:0]          sig_in,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [TS_W+2*NUM_CH-1:0]   evt_data,
    input  logic                       drv_valid,
    output logic                       drv_ready,
    input  logic [ID_W-1:0]            drv_id,
    input  logic                       drv_val,
    output logic [NUM_CH-1:0]          drv_out,
    output logic                       drv_err,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LW    = c_AW + 1;
    localparam int c_DW    = TS_W + 2*NUM_CH;
    localparam int c_IDW1  = ID_W + 1;

    localparam logic [c_LW-1:0]   c_FULL   = c_LW'(DEPTH);
    localparam logic [c_IDW1-1:0] c_NUM_CH = c_IDW1'(NUM_CH);

    localparam logic [1:0] c_PAUSED = 2'd0;
    localparam logic [1:0] c_PRIME  = 2'd1;
    localparam logic [1:0] c_RUN    = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [TS_W-1:0]   r_ts;
    logic [NUM_CH-1:0] r_prev;
    logic [c_DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_LW-1:0]   r_level;
    logic [CNT_W-1:0]  r_ovf_cnt;
    logic [NUM_CH-1:0] r_drv_out;
    logic              r_drv_err;
    logic              r_drv_ready;

    logic              w_push;
    logic [NUM_CH-1:0] w_mask;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic              w_drv_acc;
    logic              w_drv_bad;
    logic [NUM_CH-1:0] w_drv_nxt;

    // Capture FSM: PRIME emits a full snapshot so the host can re-synchronise.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_mask      = sig_in ^ r_prev;
        case (r_state)
            c_PAUSED: begin
                if (en) w_state_nxt = c_PRIME;
            end
            c_PRIME: begin
                w_push      = 1'b1;
                w_mask      = '1;
                w_state_nxt = en ? c_RUN : c_PAUSED;
            end
            c_RUN: begin
                w_push = |w_mask;
                if (!en) w_state_nxt = c_PAUSED;
            end
            default: w_state_nxt = c_PAUSED;
        endcase
    end

    assign evt_valid = (r_level != '0);
    assign w_full    = (r_level == c_FULL);
    assign w_pop     = evt_valid & evt_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_comb begin
        w_drv_acc = drv_valid & r_drv_ready;
        w_drv_bad = w_drv_acc & ({1'b0, drv_id} >= c_NUM_CH);
        w_drv_nxt = r_drv_out;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_drv_acc && (drv_id == ID_W'(i))) w_drv_nxt[i] = drv_val;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= {r_ts, w_mask, sig_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_PAUSED;
            r_ts        <= '0;
            r_prev      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_ovf_cnt   <= '0;
            r_drv_out   <= DRV_INIT;
            r_drv_err   <= 1'b0;
            r_drv_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ts        <= r_ts + TS_W'(1);
            r_prev      <= sig_in;
            r_drv_ready <= 1'b1;
            r_drv_out   <= w_drv_nxt;
            if (w_drv_bad) r_drv_err <= 1'b1;
            if (w_wr_en)   r_wr_ptr  <= r_wr_ptr + c_AW'(1);
            if (w_pop)     r_rd_ptr  <= r_rd_ptr + c_AW'(1);
            r_level <= r_level + c_LW'(w_wr_en) - c_LW'(w_pop);
            if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign evt_data   = r_mem[r_rd_ptr];
    assign fifo_level = r_level;
    assign ovf_cnt    = r_ovf_cnt;
    assign drv_out    = r_drv_out;
    assign drv_err    = r_drv_err;
    assign drv_ready  = r_drv_ready;

endmodule
`default_nettype wire
